// File: rtl/reg_file_scb_pkg.sv
// Shared definitions for the register file with scoreboard: default
// geometry and the encoding of the clear/run controller.
package reg_file_scb_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_READ   = 2;
  localparam int DEF_NUM_WRITE  = 1;

  // INIT walks the array writing zeros; RUN accepts traffic until reset.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register. A reserve sets the
// flag, a write clears it, and a reserve beats a write to the same register.
// Incoming write/reserve strobes are already qualified by the parent
// (RUN state, nonzero address).
module reg_scoreboard
  import reg_file_scb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int NUM_WRITE  = DEF_NUM_WRITE,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WRITE-1:0]           wr_q_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                           rsv_q_i,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_READ-1:0]            rd_busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]    r_busy;
  logic [DEPTH-1:0]    w_busy_nxt;
  logic [NUM_READ-1:0] w_wr_hit;
  logic [NUM_READ-1:0] w_rsv_hit;

  // Next busy vector: clears from writes first, then sets from the reserve.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_q_i[j]) w_busy_nxt[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (rsv_q_i) w_busy_nxt[rsv_addr_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Busy register; cleared synchronously by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Per read port: does a same-cycle write or reserve target its address.
  always_comb begin
    w_wr_hit  = '0;
    w_rsv_hit = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_q_i[j] &&
            (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]))
          w_wr_hit[k] = 1'b1;
      end
      w_rsv_hit[k] = rsv_q_i && (rsv_addr_i == rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  // Busy readout; a same-cycle write forwards its clear unless a reserve also lands there.
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_busy_o[k] = r_busy[rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]] &&
                     !((BYPASS != 0) && w_wr_hit[k] && !w_rsv_hit[k]);
    end
  end

endmodule

// File: rtl/reg_file_scb.sv
// Multi-ported register file with write-to-read forwarding and a busy
// scoreboard. After reset an INIT walk zeroes every entry, then the block
// sits in RUN. Register 0 is hardwired to zero and never busy.
module reg_file_scb
  import reg_file_scb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int NUM_WRITE  = DEF_NUM_WRITE,
  parameter int BYPASS     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data_o,
  output logic [NUM_READ-1:0]             rd_busy_o,
  input  logic [NUM_WRITE-1:0]            wr_en_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data_i,
  input  logic                            rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr_i,
  output logic                            ready_o
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  fsm_state_e              r_state;
  fsm_state_e              w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_idx;
  logic [ADDR_WIDTH-1:0]   w_clr_idx_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    w_run;
  logic [NUM_WRITE-1:0]    w_wr_q;
  logic                    w_rsv_q;
  logic [NUM_READ-1:0]     w_sb_busy;

  assign w_run   = (r_state == RUN);
  assign ready_o = w_run;

  // Qualified writes: enabled, in RUN, and not aimed at register 0.
  always_comb begin
    w_wr_q = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      w_wr_q[j] = wr_en_i[j] && w_run && (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] != '0);
    end
  end

  assign w_rsv_q = rsv_en_i && w_run && (rsv_addr_i != '0);

  // Controller state and clear index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= INIT;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Controller next state: walk every entry once, then stay in RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    unique case (r_state)
      INIT: begin
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == LAST_IDX) w_state_nxt = RUN;
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // Array update: zero fill during INIT, qualified writes in RUN (highest port last, so it wins).
  always_ff @(posedge clk) begin
    // NOTE: the array deliberately has no reset branch so it maps onto distributed RAM; INIT clears it.
    if (!w_run) begin
      r_mem[r_clr_idx] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (w_wr_q[j])
          r_mem[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read ports: array value, optionally overridden by a same-cycle write, forced to zero for x0 or in INIT.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (w_wr_q[j] &&
              (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]))
            rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (!w_run || (rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == '0))
        rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .NUM_WRITE  (NUM_WRITE),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_q_i     (w_wr_q),
    .wr_addr_i  (wr_addr_i),
    .rsv_q_i    (w_rsv_q),
    .rsv_addr_i (rsv_addr_i),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (w_sb_busy)
  );

  assign rd_busy_o = w_run ? w_sb_busy : '0;

endmodule

// File: tb/tb_reg_file_scb.sv
// Bench for reg_file_scb. Two instances share stimulus: dut_a (BYPASS=1,
// two write ports) and dut_b (BYPASS=0, one write port, fed from port 0).
// Expected read results come from a bench-side model, are queued when the
// stimulus is driven, and are popped and compared on the falling edge.
module tb_reg_file_scb;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic            reset;
  logic [2*AW-1:0] rd_addr;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic [1:0]      wr_en_a;
  logic [2*AW-1:0] wr_addr_a;
  logic [2*DW-1:0] wr_data_a;
  logic [0:0]      wr_en_b;
  logic [AW-1:0]   wr_addr_b;
  logic [DW-1:0]   wr_data_b;
  logic [2*DW-1:0] rd_data_a, rd_data_b;
  logic [1:0]      rd_busy_a, rd_busy_b;
  logic            ready_a, ready_b;

  reg_file_scb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .wr_en_i(wr_en_a), .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .ready_o(ready_a));

  reg_file_scb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wr_en_i(wr_en_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .ready_o(ready_b));

  typedef struct {
    logic          reset;
    logic [AW-1:0] ra0, ra1;
    logic [1:0]    we;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic          rsv;
    logic [AW-1:0] rsv_a;
  } stim_t;

  typedef struct {
    string         tag;
    int            inst;
    int            port;
    logic [DW-1:0] data;
    logic          busy;
    logic          ready;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: instance A (bypass, 2 write ports) and B.
  logic [DW-1:0] ma_mem [32];
  logic [DW-1:0] mb_mem [32];
  logic [31:0]   ma_busy, mb_busy;
  logic          m_ready;
  int            m_cnt;

  function automatic stim_t idle();
    stim_t s;
    s.reset = 1'b0; s.ra0 = '0; s.ra1 = '0; s.we = 2'b00;
    s.wa0 = '0; s.wa1 = '0; s.wd0 = '0; s.wd1 = '0;
    s.rsv = 1'b0; s.rsv_a = '0;
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int inst, input logic [AW-1:0] a, input stim_t s);
    logic [DW-1:0] d;
    if (!m_ready || a == '0) return '0;
    d = (inst == 0) ? ma_mem[a] : mb_mem[a];
    if (inst == 0) begin
      if (s.we[0] && s.wa0 == a) d = s.wd0;
      if (s.we[1] && s.wa1 == a) d = s.wd1;
    end
    return d;
  endfunction

  function automatic logic exp_busy(input int inst, input logic [AW-1:0] a, input stim_t s);
    logic b;
    if (!m_ready || a == '0) return 1'b0;
    b = (inst == 0) ? ma_busy[a] : mb_busy[a];
    if (inst == 0 && ((s.we[0] && s.wa0 == a) || (s.we[1] && s.wa1 == a)) &&
        !(s.rsv && s.rsv_a == a))
      b = 1'b0;
    return b;
  endfunction

  task automatic commit(input stim_t s);
    if (s.reset) begin
      for (int i = 0; i < 32; i++) begin ma_mem[i] = '0; mb_mem[i] = '0; end
      ma_busy = '0; mb_busy = '0; m_ready = 1'b0; m_cnt = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) m_ready = 1'b1;
    end else begin
      if (s.we[0] && s.wa0 != '0) begin
        ma_mem[s.wa0] = s.wd0; ma_busy[s.wa0] = 1'b0;
        mb_mem[s.wa0] = s.wd0; mb_busy[s.wa0] = 1'b0;
      end
      if (s.we[1] && s.wa1 != '0) begin
        ma_mem[s.wa1] = s.wd1; ma_busy[s.wa1] = 1'b0;
      end
      if (s.rsv && s.rsv_a != '0) begin
        ma_busy[s.rsv_a] = 1'b1; mb_busy[s.rsv_a] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of stimulus, queue expectations, advance past the edge.
  task automatic apply(input stim_t s, input string tag);
    exp_t e;
    reset     = s.reset;
    rd_addr   = {s.ra1, s.ra0};
    wr_en_a   = s.we;
    wr_addr_a = {s.wa1, s.wa0};
    wr_data_a = {s.wd1, s.wd0};
    wr_en_b   = s.we[0];
    wr_addr_b = s.wa0;
    wr_data_b = s.wd0;
    rsv_en    = s.rsv;
    rsv_addr  = s.rsv_a;
    if (!s.reset) begin
      for (int inst = 0; inst < 2; inst++) begin
        for (int p = 0; p < 2; p++) begin
          e.tag   = tag;
          e.inst  = inst;
          e.port  = p;
          e.data  = exp_data(inst, (p == 0) ? s.ra0 : s.ra1, s);
          e.busy  = exp_busy(inst, (p == 0) ? s.ra0 : s.ra1, s);
          e.ready = m_ready;
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    commit(s);
  endtask

  // Scoreboard: compare every queued expectation on the falling edge.
  exp_t          sb_e;
  logic [DW-1:0] sb_d;
  logic          sb_b, sb_r;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      sb_e = q.pop_front();
      sb_d = (sb_e.inst == 0) ? rd_data_a[sb_e.port*DW +: DW] : rd_data_b[sb_e.port*DW +: DW];
      sb_b = (sb_e.inst == 0) ? rd_busy_a[sb_e.port] : rd_busy_b[sb_e.port];
      sb_r = (sb_e.inst == 0) ? ready_a : ready_b;
      n_vec++;
      if (sb_d !== sb_e.data || sb_b !== sb_e.busy || sb_r !== sb_e.ready) begin
        n_err++;
        $display("FAIL %s dut_%s port%0d: got data=%h busy=%b ready=%b, expected data=%h busy=%b ready=%b",
                 sb_e.tag, (sb_e.inst == 0) ? "a" : "b", sb_e.port, sb_d, sb_b, sb_r,
                 sb_e.data, sb_e.busy, sb_e.ready);
      end
    end
  end

  // Reset pulse, then the INIT walk; ready must rise on cycle 32 exactly.
  task automatic test_reset(input string tag);
    stim_t s;
    s = idle(); s.reset = 1'b1;
    apply(s, {tag, "_pulse"});
    for (int c = 0; c < 34; c++) begin
      n_vec++;
      if (ready_a !== (c >= 32) || ready_b !== (c >= 32)) begin
        n_err++;
        $display("FAIL %s_ready cycle %0d: got a=%b b=%b, expected %b", tag, c, ready_a, ready_b, c >= 32);
      end
      s = idle();
      s.ra0 = 5'(c);
      s.ra1 = ~5'(c);
      if (c == 5) begin   // traffic during INIT must be ignored
        s.we = 2'b11; s.wa0 = 5'd4; s.wd0 = 32'hCAFE0004; s.wa1 = 5'd6; s.wd1 = 32'hCAFE0006;
        s.rsv = 1'b1; s.rsv_a = 5'd4;
      end
      if (c >= 32) begin s.ra0 = 5'd4; s.ra1 = 5'd6; end
      apply(s, tag);
    end
  endtask

  task automatic test_bypass();
    stim_t s;
    s = idle(); s.we = 2'b01; s.wa0 = 5'd5; s.wd0 = 32'hDEADBEEF; s.ra0 = 5'd5; s.ra1 = 5'd6;
    apply(s, "bypass_same");
    s = idle(); s.ra0 = 5'd5; s.ra1 = 5'd5;
    apply(s, "bypass_next");
  endtask

  task automatic test_reg_zero();
    stim_t s;
    s = idle(); s.we = 2'b11; s.wa0 = '0; s.wd0 = 32'h12345678; s.wa1 = '0; s.wd1 = 32'h87654321;
    s.rsv = 1'b1; s.rsv_a = '0; s.ra0 = '0; s.ra1 = '0;
    apply(s, "x0_write");
    s = idle();
    apply(s, "x0_after");
  endtask

  task automatic test_scoreboard();
    stim_t s;
    s = idle(); s.rsv = 1'b1; s.rsv_a = 5'd7; s.ra0 = 5'd7;
    apply(s, "rsv_x7");
    s = idle(); s.ra0 = 5'd7; s.ra1 = 5'd8;
    apply(s, "busy_x7");
    s = idle(); s.we = 2'b01; s.wa0 = 5'd7; s.wd0 = 32'h55; s.rsv = 1'b1; s.rsv_a = 5'd7; s.ra0 = 5'd7;
    apply(s, "wr_rsv_x7");
    s = idle(); s.ra0 = 5'd7;
    apply(s, "still_busy_x7");
    s = idle(); s.we = 2'b01; s.wa0 = 5'd7; s.wd0 = 32'h66; s.ra0 = 5'd7; s.ra1 = 5'd7;
    apply(s, "clear_x7");
    s = idle(); s.ra0 = 5'd7; s.ra1 = 5'd7;
    apply(s, "idle_x7");
  endtask

  task automatic test_dual_write();
    stim_t s;
    s = idle(); s.we = 2'b11; s.wa0 = 5'd3; s.wd0 = 32'h1; s.wa1 = 5'd3; s.wd1 = 32'h2;
    s.ra0 = 5'd3; s.ra1 = 5'd3;
    apply(s, "dual_x3");
    s = idle(); s.ra0 = 5'd3;
    apply(s, "dual_x3_next");
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 1; i < 32; i++) begin
      s = idle();
      s.we  = 2'b01; s.wa0 = 5'(i); s.wd0 = $urandom();
      s.ra0 = 5'(i); s.ra1 = 5'(i - 1);
      s.rsv = (i % 4 == 0); s.rsv_a = 5'(i);
      if (i % 5 == 0) begin s.we = 2'b10; s.wa1 = 5'(i); s.wd1 = $urandom(); end
      apply(s, "b2b_write");
    end
    for (int i = 0; i < 32; i += 2) begin
      s = idle(); s.ra0 = 5'(i); s.ra1 = 5'(i + 1);
      apply(s, "b2b_read");
    end
  endtask

  task automatic test_reset_run();
    stim_t s;
    s = idle(); s.we = 2'b01; s.wa0 = 5'd9; s.wd0 = 32'hA5; s.rsv = 1'b1; s.rsv_a = 5'd10;
    apply(s, "pre_x9");
    s = idle(); s.ra0 = 5'd9; s.ra1 = 5'd10;
    apply(s, "pre_read");
    test_reset("rerun");
    for (int i = 0; i < 32; i += 2) begin
      s = idle(); s.ra0 = 5'(i); s.ra1 = 5'(i + 1);
      apply(s, "post_reset_sweep");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin ma_mem[i] = '0; mb_mem[i] = '0; end
    ma_busy = '0; mb_busy = '0; m_ready = 1'b0; m_cnt = 0;
    test_reset("reset");
    test_bypass();
    test_reg_zero();
    test_scoreboard();
    test_dual_write();
    test_back_to_back();
    test_reset_run();
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_scb.md
REG_FILE_SCB -- requirements
Module: reg_file_scb

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width; depth = 2**ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 32, register width in bits.
REQ-003 Parameter NUM_READ, default 2, number of read ports (1-4).
REQ-004 Parameter NUM_WRITE, default 1, number of write ports (1-2).
REQ-005 Parameter BYPASS, default 1, enables write-to-read forwarding in the same cycle.
REQ-006 Ports, in order:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous and active-high.
- rd_addr_i  in  NUM_READ*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data_o  out  NUM_READ*DATA_WIDTH  read data per port.
- rd_busy_o  out  NUM_READ  scoreboard busy flag of each addressed register.
- wr_en_i  in  NUM_WRITE  write enables.
- wr_addr_i  in  NUM_WRITE*ADDR_WIDTH  write addresses.
- wr_data_i  in  NUM_WRITE*DATA_WIDTH  write data.
- rsv_en_i  in  1  reserve request: mark a destination as pending.
- rsv_addr_i  in  ADDR_WIDTH  register to reserve.
- ready_o  out  1  high when the array is initialised and accepting traffic.

Function
REQ-007 Register 0 SHALL always read zero and never be busy; writes and reserves to it are discarded.
REQ-008 Reads SHALL be combinational from the array; with BYPASS=1, a same-cycle qualified write to a read address SHALL be forwarded to rd_data_o.
REQ-009 With BYPASS=0, a write SHALL become visible on rd_data_o in the cycle after its rising edge.
REQ-010 When both write ports target the same register in one cycle, port NUM_WRITE-1 SHALL win for data and for bypass.
REQ-011 The scoreboard SHALL hold one busy bit per register: rsv_en_i sets busy[rsv_addr_i], and a qualified write to an address clears its busy bit.
REQ-012 When a reserve and a write hit the same register in one cycle, the array SHALL take the write data and busy SHALL end set (reserve wins).
REQ-013 rd_busy_o[k] SHALL reflect registered busy state, except that with BYPASS=1 a same-cycle write to the address SHALL clear it combinationally unless a same-cycle reserve also targets it.
REQ-014 The FSM SHALL have states INIT and RUN; INIT writes zero to entry clr_idx each cycle, clr_idx counting from 0 to 2**ADDR_WIDTH-1, then moves to RUN.
REQ-015 In INIT, ready_o SHALL be 0, wr_en_i and rsv_en_i SHALL be ignored, and rd_data_o and rd_busy_o SHALL be all zero.
REQ-016 In RUN, ready_o SHALL be 1 and the FSM SHALL remain there until reset.
REQ-017 A qualified write SHALL require wr_en_i[j]=1, state RUN, and a nonzero address.

Reset
REQ-018 While reset is high, the FSM SHALL go to INIT, clr_idx to 0, all busy bits to 0, and ready_o to 0 at the next edge.
REQ-019 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear sequence; ready_o SHALL rise exactly 2**ADDR_WIDTH cycles after the first edge with reset low.
REQ-020 The array SHALL have no per-entry reset, so it maps to distributed RAM; only the INIT walk clears it.

Structure
REQ-021 The FSM state encoding (INIT, RUN) and default widths SHALL live in the shared core package.
REQ-022 The scoreboard (busy bits, set/clear priority, busy bypass) SHALL be a sub-module, reg_scoreboard; the array, bypass muxes and FSM stay in reg_file_scb.

Verification
REQ-023 Reset for 1 cycle, then idle -> ready_o=0 for 32 cycles, 1 on cycle 32; all reads return 0.
REQ-024 In RUN, write x5=0xDEADBEEF while reading x5 on port 0 -> BYPASS=1: 0xDEADBEEF same cycle; BYPASS=0: old value, then 0xDEADBEEF next cycle.
REQ-025 Write x0=0x12345678 and reserve x0 -> reads of x0 return 0, rd_busy_o=0.
REQ-026 Reserve x7; next cycle read x7 -> busy=1; write x7=0x55 with reserve x7 the same cycle -> data 0x55, busy stays 1; a later write with no reserve clears busy.
REQ-027 NUM_WRITE=2, both ports write x3 (0x1, 0x2) -> x3 reads 0x2.
REQ-028 Assert reset during RUN after writing x9=0xA5 -> ready_o low for 32 cycles; afterwards x9 reads 0 and no register is busy.
